// File: rtl/hex_tx_pkg.sv
// Shared types and ASCII constants for the hex transmit formatter.
package hex_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEX  = 2'd1,
    CR   = 2'd2,
    LF   = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational map of a 4-bit value to its uppercase ASCII hex digit.
module hex_nibble_to_ascii
  import hex_tx_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_0 + {4'h0, nibble};
    else                ascii = ASCII_A + {4'h0, nibble} - 8'd10;
  end

endmodule

// File: rtl/hex_tx_formatter.sv
// Prints each accepted word as uppercase hex (MS nibble first), optionally
// followed by CR LF, one byte per transfer to the UART bridge.
module hex_tx_formatter
  import hex_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] word_din,
  input  logic                  word_vld,
  output logic                  word_rdy,
  output logic [7:0]            tx_din,
  output logic                  tx_vld,
  input  logic                  busy,
  output logic                  idle
);

  localparam int NCH   = DATA_WIDTH / 4;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [7:0]            hex_char;
  logic                  accept;
  logic                  last_nib;

  hex_nibble_to_ascii u_nib (
    .nibble (shreg_q[DATA_WIDTH-1 -: 4]),
    .ascii  (hex_char)
  );

  assign accept   = (state_q == IDLE) && word_vld;
  assign last_nib = (cnt_q == CNT_W'(NCH - 1));
  assign idle     = (state_q == IDLE);

  // Outputs depend only on registered state, so they hold still under busy.
  always_comb begin
    state_d  = state_q;
    word_rdy = 1'b0;
    tx_vld   = 1'b0;
    tx_din   = 8'h00;
    case (state_q)
      IDLE: begin
        word_rdy = 1'b1;
        if (word_vld) state_d = HEX;
      end
      HEX: begin
        tx_vld = 1'b1;
        tx_din = hex_char;
        if (!busy && last_nib) state_d = APPEND_CRLF ? CR : IDLE;
      end
      CR: begin
        tx_vld = 1'b1;
        tx_din = ASCII_CR;
        if (!busy) state_d = LF;
      end
      LF: begin
        tx_vld = 1'b1;
        tx_din = ASCII_LF;
        if (!busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        shreg_q <= word_din;
        cnt_q   <= '0;
      end else if (state_q == HEX && !busy && !last_nib) begin
        // Shift the next nibble into the MS position after each transfer.
        shreg_q <= shreg_q << 4;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hex_tx_formatter.sv
// Bench for hex_tx_formatter: a 32-bit CRLF instance and an 8-bit no-CRLF instance.
module tb_hex_tx_formatter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] a_din = '0;
  logic        a_vld = 1'b0, a_busy = 1'b0;
  logic        a_rdy, a_tv, a_idle;
  logic [7:0]  a_td;
  logic [7:0]  b_din = '0;
  logic        b_vld = 1'b0, b_busy = 1'b0;
  logic        b_rdy, b_tv, b_idle;
  logic [7:0]  b_td;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  string hexs = "0123456789ABCDEF";

  hex_tx_formatter #(.DATA_WIDTH(32), .APPEND_CRLF(1'b1)) dut_a (
    .clk(clk), .rst(rst), .word_din(a_din), .word_vld(a_vld), .word_rdy(a_rdy),
    .tx_din(a_td), .tx_vld(a_tv), .busy(a_busy), .idle(a_idle));

  hex_tx_formatter #(.DATA_WIDTH(8), .APPEND_CRLF(1'b0)) dut_b (
    .clk(clk), .rst(rst), .word_din(b_din), .word_vld(b_vld), .word_rdy(b_rdy),
    .tx_din(b_td), .tx_vld(b_tv), .busy(b_busy), .idle(b_idle));

  // Scoreboards: inputs change at posedge+1, so at negedge the next edge's
  // transfers and acceptances are already decided.
  always @(negedge clk) begin : mon_a
    logic [7:0] e;
    if (rst) qa.delete();
    else begin
      if (a_tv && !a_busy) begin
        n_vec++;
        if (qa.size() == 0) begin
          n_err++;
          $display("FAIL a_stream: got byte %02h, want no byte", a_td);
        end else begin
          e = qa.pop_front();
          if (a_td !== e) begin
            n_err++;
            $display("FAIL a_stream: got %02h want %02h", a_td, e);
          end
        end
      end
      if (a_vld && a_rdy) begin
        for (int i = 7; i >= 0; i--) qa.push_back(hexs[a_din[i*4 +: 4]]);
        qa.push_back(8'h0D);
        qa.push_back(8'h0A);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [7:0] e;
    if (rst) qb.delete();
    else begin
      if (b_tv && !b_busy) begin
        n_vec++;
        if (qb.size() == 0) begin
          n_err++;
          $display("FAIL b_stream: got byte %02h, want no byte", b_td);
        end else begin
          e = qb.pop_front();
          if (b_td !== e) begin
            n_err++;
            $display("FAIL b_stream: got %02h want %02h", b_td, e);
          end
        end
      end
      if (b_vld && b_rdy) begin
        qb.push_back(hexs[b_din[7:4]]);
        qb.push_back(hexs[b_din[3:0]]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain_a(input string name);
    int c = 0;
    while (!(a_idle && qa.size() == 0) && c < 100) begin
      tick();
      c++;
    end
    n_vec++;
    if (c >= 100) begin
      n_err++;
      $display("FAIL %s_drain: still busy after %0d cycles, %0d bytes pending, want idle", name, c, qa.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({a_tv, a_td, a_rdy, a_idle} !== {1'b0, 8'h00, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL reset_a_during: got vld=%b din=%02h rdy=%b idle=%b want 0 00 1 1", a_tv, a_td, a_rdy, a_idle);
    end
    n_vec++;
    if ({b_tv, b_td, b_rdy, b_idle} !== {1'b0, 8'h00, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL reset_b_during: got vld=%b din=%02h rdy=%b idle=%b want 0 00 1 1", b_tv, b_td, b_rdy, b_idle);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({a_tv, a_td, a_rdy, a_idle} !== {1'b0, 8'h00, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL reset_a_after: got vld=%b din=%02h rdy=%b idle=%b want 0 00 1 1", a_tv, a_td, a_rdy, a_idle);
    end
  endtask

  task automatic test_deadbeef;
    logic [7:0] exp [10] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    a_din = 32'hDEADBEEF;
    a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if ({a_tv, a_td} !== {1'b1, exp[i]}) begin
        n_err++;
        $display("FAIL deadbeef_byte%0d: got vld=%b din=%02h want 1 %02h", i, a_tv, a_td, exp[i]);
      end
      tick();
    end
    n_vec++;
    if ({a_tv, a_rdy, a_idle} !== 3'b011) begin
      n_err++;
      $display("FAIL deadbeef_end: got vld=%b rdy=%b idle=%b want 0 1 1", a_tv, a_rdy, a_idle);
    end
  endtask

  task automatic test_stall;
    a_din = 32'h0000000A;
    a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
    tick();
    a_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({a_tv, a_td} !== {1'b1, 8'h30}) begin
        n_err++;
        $display("FAIL stall_hold%0d: got vld=%b din=%02h want 1 30", k, a_tv, a_td);
      end
      if (k == 3) a_busy = 1'b0;
      else tick();
    end
    wait_drain_a("stall");
  endtask

  task automatic test_back_to_back;
    a_din = 32'h12345678;
    a_vld = 1'b1;
    tick();
    a_din = 32'h9ABCDEF0;
    for (int i = 0; i < 21; i++) begin
      n_vec++;
      if (a_tv !== (i != 10)) begin
        n_err++;
        $display("FAIL b2b_vld%0d: got %b want %b", i, a_tv, (i != 10));
      end
      n_vec++;
      if (a_rdy !== (i == 10)) begin
        n_err++;
        $display("FAIL b2b_rdy%0d: got %b want %b", i, a_rdy, (i == 10));
      end
      if (i == 11) a_vld = 1'b0;
      tick();
    end
    wait_drain_a("b2b");
  endtask

  task automatic test_din_change;
    a_din = 32'h89ABCDEF;
    a_vld = 1'b1;
    tick();
    a_din = 32'h01234567;
    a_vld = 1'b0;
    n_vec++;
    if (a_td !== 8'h38) begin
      n_err++;
      $display("FAIL din_change_first: got %02h want 38", a_td);
    end
    tick();
    a_din = 32'hFFFFFFFF;
    wait_drain_a("din_change");
  endtask

  task automatic test_reset_midword;
    a_din = 32'hCAFEF00D;
    a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
    repeat (4) tick();
    n_vec++;
    if ({a_tv, a_td} !== {1'b1, 8'h46}) begin
      n_err++;
      $display("FAIL rstmid_fifth: got vld=%b din=%02h want 1 46", a_tv, a_td);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({a_tv, a_idle, a_td} !== {1'b0, 1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL rstmid_abandon: got vld=%b idle=%b din=%02h want 0 1 00", a_tv, a_idle, a_td);
    end
    repeat (3) tick();
    a_din = 32'h00000001;
    a_vld = 1'b1;
    tick();
    a_vld = 1'b0;
    n_vec++;
    if ({a_tv, a_td} !== {1'b1, 8'h30}) begin
      n_err++;
      $display("FAIL rstmid_restart: got vld=%b din=%02h want 1 30", a_tv, a_td);
    end
    wait_drain_a("rstmid");
  endtask

  task automatic test_no_crlf;
    b_din = 8'h7F;
    b_vld = 1'b1;
    tick();
    b_vld = 1'b0;
    n_vec++;
    if ({b_tv, b_td} !== {1'b1, 8'h37}) begin
      n_err++;
      $display("FAIL nocrlf_b0: got vld=%b din=%02h want 1 37", b_tv, b_td);
    end
    tick();
    n_vec++;
    if ({b_tv, b_td} !== {1'b1, 8'h46}) begin
      n_err++;
      $display("FAIL nocrlf_b1: got vld=%b din=%02h want 1 46", b_tv, b_td);
    end
    tick();
    n_vec++;
    if ({b_tv, b_idle, b_rdy} !== 3'b011) begin
      n_err++;
      $display("FAIL nocrlf_end: got vld=%b idle=%b rdy=%b want 0 1 1", b_tv, b_idle, b_rdy);
    end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_deadbeef();
    test_stall();
    test_back_to_back();
    test_din_change();
    test_reset_midword();
    test_no_crlf();
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL pending_bytes: got a=%0d b=%0d want 0 0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
